// File: rtl/pwm_clk_pkg.sv
// Shared types for the PWM / clock waveform controller: FSM states, config
// record and the default counter width.
package pwm_clk_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } pwm_state_t;

    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] period;
        logic [CNT_W_DEFAULT-1:0] high;
        logic [CNT_W_DEFAULT-1:0] phase;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_cfg_regs.sv
// Config side of the PWM controller: handshake, validation, the pending and
// active registers, and the pending->active transfer requested by the FSM.
module pwm_cfg_regs #(
    parameter int CNT_W = pwm_clk_pkg::CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             xfer,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] use_period,
    output logic [CNT_W-1:0] use_high,
    output logic [CNT_W-1:0] use_phase,
    output logic             use_valid
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

    cfg_t pend_q, pend_d;
    cfg_t act_q, act_d;
    cfg_t offer;
    cfg_t use_cfg;
    logic pend_valid_q, pend_valid_d;
    logic act_valid_q, act_valid_d;
    logic cfg_err_q, cfg_err_d;
    logic offer_ok;
    logic accept;
    logic do_xfer;

    // Handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
    // The offer must hold steady while cfg_valid is high and cfg_ready is low;
    // cfg_ready depends only on registered state, never on cfg_valid.
    always_comb begin
        offer        = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
        offer_ok     = (cfg_period >= MIN_PERIOD) && (cfg_high != '0) &&
                       (cfg_high < cfg_period);
        accept       = cfg_valid && !pend_valid_q;
        do_xfer      = xfer && pend_valid_q;

        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        act_valid_d  = act_valid_q;
        cfg_err_d    = accept && !offer_ok;

        if (do_xfer) begin
            act_d        = pend_q;
            act_valid_d  = 1'b1;
            pend_valid_d = 1'b0;
        end
        // accept and do_xfer are exclusive: one needs pending empty, the other full
        if (accept && offer_ok) begin
            pend_d       = offer;
            pend_valid_d = 1'b1;
        end

        // Settings in force after this edge, so the FSM reloads with new values
        // on the same edge that performs the transfer.
        use_cfg      = do_xfer ? pend_q : act_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            act_q        <= act_d;
            act_valid_q  <= act_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready  = !pend_valid_q;
    assign cfg_err    = cfg_err_q;
    assign use_period = use_cfg.period;
    assign use_high   = use_cfg.high;
    assign use_phase  = use_cfg.phase;
    assign use_valid  = act_valid_q || do_xfer;

endmodule

// File: rtl/pwm_clk_ctrl.sv
// Runtime-programmable PWM / clock generator: phase delay, then repeating
// HIGH/LOW periods; new settings take effect only at period boundaries.
module pwm_clk_ctrl
    import pwm_clk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             wave_out,
    output logic             period_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_start_q, period_start_d;
    logic [CNT_W-1:0] use_period, use_high, use_phase;
    logic             use_valid;
    logic             xfer;
    logic             cnt_done;

    pwm_cfg_regs #(.CNT_W(CNT_W)) u_cfg_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .xfer       (xfer),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .use_period (use_period),
        .use_high   (use_high),
        .use_phase  (use_phase),
        .use_valid  (use_valid)
    );

    always_comb begin
        cnt_done = (cnt_q == '0);
        // Pending settings may only land while idle or as the last LOW cycle ends
        xfer     = (state_q == ST_IDLE) || ((state_q == ST_LOW) && cnt_done);
        state_d  = state_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en && use_valid) begin
                    if (use_phase == '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = use_high - ONE;
                    end else begin
                        state_d = ST_PHASE;
                        cnt_d   = use_phase - ONE;
                    end
                end
            end
            ST_PHASE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = ST_HIGH;
                    cnt_d   = use_high - ONE;
                end else begin
                    cnt_d   = cnt_q - ONE;
                end
            end
            ST_HIGH: begin
                if (cnt_done) begin
                    // Validation guarantees period > high, so this never wraps
                    state_d = ST_LOW;
                    cnt_d   = use_period - use_high - ONE;
                end else begin
                    cnt_d   = cnt_q - ONE;
                end
            end
            ST_LOW: begin
                if (cnt_done) begin
                    if (en) begin
                        state_d = ST_HIGH;
                        cnt_d   = use_high - ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d   = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        period_start_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign wave_out     = (state_q == ST_HIGH);
    assign period_start = period_start_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_clk_ctrl.sv
// Bench for pwm_clk_ctrl: directed scenarios plus randomized configs, every
// output compared each cycle against a period-position reference model.
module tb_pwm_clk_ctrl;
    import pwm_clk_pkg::*;

    localparam int W = CNT_W_DEFAULT;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_period, cfg_high, cfg_phase;
    logic         cfg_ready, cfg_err, wave_out, period_start, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_q[$];
    logic prev_wave = 1'b0;

    // Reference model: run mode 0=idle 1=delaying 2=running, m_t = elapsed
    // delay cycles or position inside the current period.
    pwm_cfg_t m_act, m_pend;
    bit       m_act_v, m_pend_v, m_err, m_hs;
    int       m_run, m_t;

    pwm_clk_ctrl #(.CNT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .cfg_phase    (cfg_phase),
        .cfg_err      (cfg_err),
        .wave_out     (wave_out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit cfg_ok(input int p, input int h);
        return (p >= 2) && (h >= 1) && (h < p);
    endfunction

    task automatic model_reset();
        m_act = '0; m_pend = '0;
        m_act_v = 0; m_pend_v = 0; m_err = 0; m_hs = 0;
        m_run = 0; m_t = 0;
    endtask

    task automatic model_edge();
        bit boundary, xfer, accept, ok, effv;
        pwm_cfg_t eff, offer_c;
        offer_c  = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
        ok       = cfg_ok(int'(cfg_period), int'(cfg_high));
        boundary = (m_run == 2) && (m_t == int'(m_act.period) - 1);
        xfer     = ((m_run == 0) || boundary) && m_pend_v;
        accept   = cfg_valid && !m_pend_v;
        eff      = xfer ? m_pend : m_act;
        effv     = m_act_v || xfer;
        case (m_run)
            0: if (en && effv) begin
                m_run = (eff.phase == '0) ? 2 : 1;
                m_t   = 0;
            end
            1: if (!en) m_run = 0;
               else if (m_t + 1 == int'(m_act.phase)) begin m_run = 2; m_t = 0; end
               else m_t++;
            default: if (boundary) begin
                if (en) m_t = 0; else m_run = 0;
            end else m_t++;
        endcase
        if (xfer) begin m_act = m_pend; m_act_v = 1; m_pend_v = 0; end
        m_hs  = accept;
        m_err = accept && !ok;
        if (accept && ok) begin m_pend = offer_c; m_pend_v = 1; end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk_bit("wave_out", wave_out, (m_run == 2) && (m_t < int'(m_act.high)));
        chk_bit("period_start", period_start, (m_run == 2) && (m_t == 0));
        chk_bit("busy", busy, m_run != 0);
        chk_bit("cfg_ready", cfg_ready, !m_pend_v);
        chk_bit("cfg_err", cfg_err, m_err);
        if (wave_out && !prev_wave) rise_q.push_back(cyc);
        prev_wave = wave_out;
    endtask

    task automatic offer(input int p, input int h, input int ph);
        int n = 0;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_phase  = W'(ph);
        cfg_valid  = 1'b1;
        do begin tick(); n++; end while (!m_hs && n < 64);
        if (!m_hs) chk_bit("offer_timeout", 1'b0, 1'b1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_period_start();
        int n = 0;
        do begin tick(); n++; end while (!(m_run == 2 && m_t == 0) && n < 64);
        if (n >= 64) chk_bit("period_start_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int en_cyc, s, p, h, ph;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0;
        model_reset();

        // Reset values
        #12;
        chk_bit("rst_wave_out", wave_out, 1'b0);
        chk_bit("rst_period_start", period_start, 1'b0);
        chk_bit("rst_cfg_ready", cfg_ready, 1'b1);
        chk_bit("rst_cfg_err", cfg_err, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // en with no active config does nothing
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        tick();

        // {10,2,3}: first rise 3 cycles after en, rises every 10
        offer(10, 2, 3);
        tick();
        rise_q.delete();
        en_cyc = cyc + 1;
        en = 1'b1;
        repeat (32) tick();
        chk_int("rise_count_10_2_3", rise_q.size(), 3);
        chk_int("phase_delay", rise_q[0] - en_cyc, 3);
        chk_int("period_10_a", rise_q[1] - rise_q[0], 10);
        chk_int("period_10_b", rise_q[2] - rise_q[1], 10);

        // en dropped during HIGH of {10,2,0} finishes the period
        en = 1'b0;
        repeat (12) tick();
        offer(10, 2, 0);
        tick();
        en = 1'b1;
        wait_period_start();
        en = 1'b0;
        repeat (9) tick();
        chk_bit("busy_last_low", busy, 1'b1);
        tick();
        chk_bit("busy_after_stop", busy, 1'b0);

        // Rejected configs
        offer(5, 0, 0);
        chk_bit("err_high0", cfg_err, 1'b1);
        tick();
        chk_bit("err_high0_clear", cfg_err, 1'b0);
        offer(5, 5, 0);
        chk_bit("err_high_eq_period", cfg_err, 1'b1);
        chk_bit("err_ready_kept", cfg_ready, 1'b1);
        tick();
        chk_bit("err_high_eq_clear", cfg_err, 1'b0);

        // Mid-HIGH change to {4,2,0}: current period completes at 10 cycles
        en = 1'b1;
        wait_period_start();
        s = cyc;
        rise_q.delete();
        offer(4, 2, 0);
        chk_bit("ready_low_while_pending", cfg_ready, 1'b0);
        repeat (22) tick();
        chk_int("old_period_done", rise_q[0] - s, 10);
        chk_int("new_period_a", rise_q[1] - rise_q[0], 4);
        chk_int("new_period_b", rise_q[2] - rise_q[1], 4);

        // Back-to-back offers: second stalls until the boundary transfer
        offer(8, 3, 0);
        offer(6, 1, 0);
        repeat (30) tick();

        // en dropped during PHASE: wave never rises
        en = 1'b0;
        repeat (12) tick();
        offer(6, 2, 4);
        tick();
        rise_q.delete();
        en = 1'b1;
        repeat (2) tick();
        chk_bit("in_phase_busy", busy, 1'b1);
        en = 1'b0;
        tick();
        repeat (5) tick();
        chk_int("phase_abort_no_rise", rise_q.size(), 0);
        chk_bit("phase_abort_idle", busy, 1'b0);

        // Randomized configs and en activity
        for (int i = 0; i < 30; i++) begin
            en = ($urandom_range(9, 0) < 8);
            p  = int'($urandom_range(12, 1));
            h  = int'($urandom_range(p + 1, 0));
            ph = int'($urandom_range(4, 0));
            offer(p, h, ph);
            repeat (int'($urandom_range(30, 5))) tick();
        end

        // Reset mid-HIGH acts immediately and clears the active config
        en = 1'b1;
        offer(10, 2, 0);
        wait_period_start();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        prev_wave = 1'b0;
        chk_bit("async_rst_wave", wave_out, 1'b0);
        chk_bit("async_rst_busy", busy, 1'b0);
        chk_bit("async_rst_ready", cfg_ready, 1'b1);
        chk_bit("async_rst_pstart", period_start, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (15) tick();
        chk_bit("no_start_after_rst", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
